// File: rtl/allpass_pkg.sv
// Shared definitions for the allpass cascade and its coefficient sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package allpass_pkg;

   // Default coefficient / datapath width shared with the cascade
   localparam int ALLPASS_WIDTH = 16;

   // Coefficient sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RAMP   = 2'd1,
      ST_SETTLE = 2'd2
   } coef_state_t;

endpackage

// File: rtl/allpass_coef_ctrl.sv
// Sequences the cascade coefficient c to a host target by bounded ramp or jump+flush.
// Latency: jump lands 1 cycle after accept; ramp moves one STEP per sample_en strobe.
// Backpressure: tgt_ready low while busy and during the done cycle; no request queueing.
module allpass_coef_ctrl
   import allpass_pkg::*;
#(
   parameter int WIDTH  = ALLPASS_WIDTH,
   parameter int STEP   = 64,
   parameter int SETTLE = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    sample_en,
   input  logic                    tgt_valid,
   output logic                    tgt_ready,
   input  logic signed [WIDTH-1:0] tgt_c,
   input  logic                    tgt_jump,
   output logic signed [WIDTH-1:0] c,
   output logic                    flush,
   output logic                    busy,
   output logic                    done
);

   localparam int                      CW         = $clog2(SETTLE + 1);
   localparam logic [CW-1:0]           SETTLE_CNT = CW'(SETTLE);
   localparam logic [WIDTH:0]          STEP_MAG   = (WIDTH+1)'(STEP);
   localparam logic signed [WIDTH-1:0] STEP_C     = WIDTH'(STEP);

   coef_state_t             state;
   logic signed [WIDTH-1:0] tgt;
   logic [CW-1:0]           cnt;

   logic signed [WIDTH:0]   diff;
   logic [WIDTH:0]          diff_mag;
   logic                    land;
   logic signed [WIDTH-1:0] c_step;

   // Step/clamp: one extra bit keeps target - c exact across the full signed range
   always_comb begin
      diff     = {tgt[WIDTH-1], tgt} - {c[WIDTH-1], c};
      diff_mag = diff[WIDTH] ? -diff : diff;
      land     = (diff_mag <= STEP_MAG);
      c_step   = diff[WIDTH] ? (c - STEP_C) : (c + STEP_C);
   end

   // The done cycle still holds off requests so a new one lands in a clean IDLE cycle
   assign busy      = (state != ST_IDLE);
   assign tgt_ready = (state == ST_IDLE) && !done;

   // Sequencer FSM with registered coefficient and pulse outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         c     <= '0;
         tgt   <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         flush <= 1'b0;
      end else begin
         done  <= 1'b0;
         flush <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tgt_valid && tgt_ready) begin
                  tgt <= tgt_c;
                  if (tgt_jump) begin
                     c     <= tgt_c;
                     flush <= 1'b1;
                     cnt   <= SETTLE_CNT;
                     state <= ST_SETTLE;
                  end else begin
                     state <= ST_RAMP;
                  end
               end
            end
            ST_RAMP: begin
               if (sample_en) begin
                  if (land) begin
                     c     <= tgt;
                     cnt   <= SETTLE_CNT;
                     state <= ST_SETTLE;
                  end else begin
                     c <= c_step;
                  end
               end
            end
            ST_SETTLE: begin
               if (sample_en) begin
                  cnt <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_allpass_coef_ctrl.sv
// Self-checking bench for allpass_coef_ctrl: directed scenarios plus randomized traffic.
// Latency: an integer reference model tracks the DUT cycle by cycle.
// Backpressure: host requests are driven with random valid and held values.
module tb_allpass_coef_ctrl;

   localparam int W      = 16;
   localparam int STEP   = 64;
   localparam int SETTLE = 4;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                sample_en = 1'b0;
   logic                tgt_valid = 1'b0;
   logic                tgt_ready;
   logic signed [W-1:0] tgt_c = '0;
   logic                tgt_jump = 1'b0;
   logic signed [W-1:0] c;
   logic                flush;
   logic                busy;
   logic                done;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   allpass_coef_ctrl #(.WIDTH(W), .STEP(STEP), .SETTLE(SETTLE)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample_en (sample_en),
      .tgt_valid (tgt_valid),
      .tgt_ready (tgt_ready),
      .tgt_c     (tgt_c),
      .tgt_jump  (tgt_jump),
      .c         (c),
      .flush     (flush),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: phase 0 = waiting for host, 1 = moving toward target,
   // 2 = counting settle strobes. Coefficient kept as a plain integer.
   int m_phase = 0;
   int m_c     = 0;
   int m_tgt   = 0;
   int m_left  = 0;
   bit m_done  = 1'b0;
   bit m_flush = 1'b0;

   always @(posedge clk) begin
      automatic bit can_take = (m_phase == 0) && !m_done;
      automatic int gap;
      m_done  = 1'b0;
      m_flush = 1'b0;
      if (!rst) begin
         m_phase = 0; m_c = 0; m_tgt = 0; m_left = 0;
      end else if (m_phase == 0) begin
         if (tgt_valid && can_take) begin
            m_tgt = int'(tgt_c);
            if (tgt_jump) begin
               m_c = m_tgt; m_flush = 1'b1; m_left = SETTLE; m_phase = 2;
            end else begin
               m_phase = 1;
            end
         end
      end else if (sample_en) begin
         if (m_phase == 1) begin
            gap = m_tgt - m_c;
            if (gap <= STEP && gap >= -STEP) begin
               m_c = m_tgt; m_left = SETTLE; m_phase = 2;
            end else begin
               m_c = m_c + ((gap > 0) ? STEP : -STEP);
            end
         end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_done = 1'b1; m_phase = 0;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_c",     int'(c),   m_c);
         chk("m_flush", int'(flush), int'(m_flush));
         chk("m_done",  int'(done),  int'(m_done));
         chk("m_busy",  int'(busy),  int'(m_phase != 0));
         chk("m_ready", int'(tgt_ready), int'(m_phase == 0 && !m_done));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic req(input int v, input bit j);
      tgt_valid = 1'b1;
      tgt_c     = W'(v);
      tgt_jump  = j;
      tick();
      tgt_valid = 1'b0;
      tgt_jump  = 1'b0;
   endtask

   task automatic wait_idle();
      automatic bit ok = 1'b0;
      sample_en = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         if (!busy && tgt_ready) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk("wait_idle_timeout", 0, 1);
   endtask

   initial begin
      int strobes;
      int prev;
      int cur;
      bit seen;

      // Reset
      rst = 1'b0;
      tick(); tick();
      cmp_en = 1'b1;
      chk("rst_c", int'(c), 0);
      chk("rst_ready", int'(tgt_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_flush", int'(flush), 0);
      rst = 1'b1;
      tick();

      // Ramp up 0 -> 256 with continuous strobes
      sample_en = 1'b1;
      req(256, 1'b0);
      chk("up_busy0", int'(busy), 1);
      chk("up_c0", int'(c), 0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         chk("up_c", int'(c), (i <= 4) ? 64 * i : 256);
         chk("up_done", int'(done), (i == 8) ? 1 : 0);
         chk("up_busy", int'(busy), (i == 8) ? 0 : 1);
      end
      chk("up_ready_on_done", int'(tgt_ready), 0);
      tick();
      chk("up_ready_after", int'(tgt_ready), 1);

      // Clamped ramp down 0 -> -100 with a strobe every third cycle
      req(0, 1'b1);
      wait_idle();
      sample_en = 1'b0;
      req(-100, 1'b0);
      strobes = 0;
      for (int cyc = 1; cyc <= 9; cyc++) begin
         sample_en = (cyc % 3 == 0);
         if (sample_en) strobes++;
         tick();
         chk("dn_c", int'(c), (strobes == 0) ? 0 : (strobes == 1) ? -64 : -100);
      end
      wait_idle();

      // Jump 256 -> 1000
      req(256, 1'b0);
      wait_idle();
      chk("pre_jump_c", int'(c), 256);
      req(1000, 1'b1);
      chk("jump_c", int'(c), 1000);
      chk("jump_flush", int'(flush), 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("jump_flush_off", int'(flush), 0);
         chk("jump_done", int'(done), (i == 4) ? 1 : 0);
      end
      tick();

      // Backpressure: held request while ramping 1000 -> 0
      req(0, 1'b0);
      tgt_valid = 1'b1;
      tgt_c     = W'(500);
      tgt_jump  = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
         tick();
         chk("bp_ready", int'(tgt_ready), 0);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("bp_done_seen", int'(seen), 1);
      chk("bp_c_at_done", int'(c), 0);
      tick();
      chk("bp_ready_after", int'(tgt_ready), 1);
      chk("bp_idle_after", int'(busy), 0);
      tick();
      tgt_valid = 1'b0;
      chk("bp_accepted", int'(busy), 1);
      wait_idle();
      chk("bp_final_c", int'(c), 500);

      // Reset mid-ramp at c = 128
      req(0, 1'b1);
      wait_idle();
      req(1000, 1'b0);
      for (int n = 0; n < 20; n++) begin
         if (c == 16'sd128) break;
         tick();
      end
      chk("mr_c128", int'(c), 128);
      chk("mr_busy", int'(busy), 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mr_c", int'(c), 0);
      chk("mr_ready", int'(tgt_ready), 1);
      chk("mr_busy0", int'(busy), 0);
      tick(); tick();
      chk("mr_stays", int'(c), 0);

      // Full-scale ramp -32768 -> 32767
      req(-32768, 1'b1);
      wait_idle();
      chk("fs_start", int'(c), -32768);
      req(32767, 1'b0);
      strobes = 0;
      prev = -32768;
      for (int n = 0; n < 1100; n++) begin
         tick();
         strobes++;
         cur = int'(c);
         chk("fs_mono", int'(cur >= prev), 1);
         prev = cur;
         if (cur == 32767) break;
      end
      chk("fs_strobes", strobes, 1024);
      chk("fs_land", int'(c), 32767);
      wait_idle();

      // Randomized traffic checked by the model
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 299) != 0);
         sample_en = ($urandom_range(0, 2) != 0);
         tgt_valid = ($urandom_range(0, 2) == 0);
         tgt_c     = W'($urandom);
         if ($urandom_range(0, 1) == 0) tgt_c = W'($signed(tgt_c) >>> 6);
         tgt_jump  = ($urandom_range(0, 3) == 0);
         tick();
      end
      rst = 1'b1;
      tgt_valid = 1'b0;
      tick();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
